// File: rtl/log_spawn_scheduler.sv
`default_nettype none
// ==========================================================================
// log_spawn_scheduler : frame-paced river-log spawner with slot allocation,
//                       live-log cap and valid/ready offer.   Revision: 1.0
// ==========================================================================
module log_spawn_scheduler #(
  parameter int NUM_LOGS   = 30,
  parameter int IDX_W      = 5,
  parameter int OFFSET_W   = 9,
  parameter int SPAWN_GAP  = 8,
  parameter int MAX_ACTIVE = 8
) (
  input  logic                CLK,
  input  logic                resetN,
  input  logic                enable,
  input  logic                startOfFrame,
  output logic [IDX_W-1:0]    table_idx,
  input  logic [OFFSET_W-1:0] offset_x_in,
  input  logic [OFFSET_W-1:0] offset_y_in,
  output logic                spawn_valid,
  input  logic                spawn_ready,
  output logic [IDX_W-1:0]    spawn_slot,
  output logic [OFFSET_W-1:0] spawn_x,
  output logic [OFFSET_W-1:0] spawn_y,
  input  logic                despawn_valid,
  input  logic [IDX_W-1:0]    despawn_slot,
  output logic [NUM_LOGS-1:0] active_mask,
  output logic [IDX_W:0]      active_count
);

  localparam int c_GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'(SPAWN_GAP - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE    = c_GAP_W'(1);
  localparam logic [IDX_W-1:0]   c_LAST_IDX   = IDX_W'(NUM_LOGS - 1);
  localparam logic [IDX_W-1:0]   c_IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W:0]     c_CNT_ONE    = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0]     c_MAX_ACTIVE = MAX_ACTIVE[IDX_W:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_GAP  = 3'd1,
    S_FIND_SLOT = 3'd2,
    S_LOOKUP    = 3'd3,
    S_OFFER     = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_GAP_W-1:0]    r_gap_cnt;
  logic [IDX_W-1:0]      r_table_idx;
  logic                  r_spawn_valid;
  logic [IDX_W-1:0]      r_spawn_slot;
  logic [OFFSET_W-1:0]   r_spawn_x;
  logic [OFFSET_W-1:0]   r_spawn_y;
  logic [NUM_LOGS-1:0]   r_active_mask;
  logic [IDX_W:0]        r_active_count;

  logic [IDX_W-1:0]      w_free_slot;
  logic                  w_desp_hit;
  logic                  w_accept;
  logic [NUM_LOGS-1:0]   w_mask_next;

  // Lowest-index clear bit; only consumed when the count is below the cap.
  always_comb begin
    w_free_slot = '0;
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      if (!r_active_mask[i]) w_free_slot = IDX_W'(i);
    end
  end

  assign w_accept   = r_spawn_valid & spawn_ready;
  assign w_desp_hit = despawn_valid && (int'(despawn_slot) < NUM_LOGS) &&
                      r_active_mask[despawn_slot];

  // The offered slot is still clear in the mask, so a same-edge despawn of
  // it never hits and the set below wins.
  always_comb begin
    w_mask_next = r_active_mask;
    if (w_desp_hit) w_mask_next[despawn_slot] = 1'b0;
    if (w_accept)   w_mask_next[r_spawn_slot] = 1'b1;
  end

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_IDLE;
      r_gap_cnt      <= '0;
      r_table_idx    <= '0;
      r_spawn_valid  <= 1'b0;
      r_spawn_slot   <= '0;
      r_spawn_x      <= '0;
      r_spawn_y      <= '0;
      r_active_mask  <= '0;
      r_active_count <= '0;
    end else begin
      r_active_mask <= w_mask_next;
      case ({w_accept, w_desp_hit})
        2'b10:   r_active_count <= r_active_count + c_CNT_ONE;
        2'b01:   r_active_count <= r_active_count - c_CNT_ONE;
        default: r_active_count <= r_active_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_WAIT_GAP;
            r_gap_cnt <= '0;
          end
        end
        S_WAIT_GAP: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
          end else if (startOfFrame) begin
            if (r_gap_cnt == c_GAP_LAST) begin
              r_gap_cnt <= '0;
              r_state   <= S_FIND_SLOT;
            end else begin
              r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
            end
          end
        end
        S_FIND_SLOT: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
          end else if (r_active_count < c_MAX_ACTIVE) begin
            r_spawn_slot <= w_free_slot;
            r_state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_spawn_x   <= offset_x_in;
            r_spawn_y   <= offset_y_in;
            r_table_idx <= (r_table_idx == c_LAST_IDX) ? '0 : r_table_idx + c_IDX_ONE;
            r_state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          // An offer is never withdrawn; enable only decides where we go after.
          if (!r_spawn_valid) begin
            r_spawn_valid <= 1'b1;
          end else if (spawn_ready) begin
            r_spawn_valid <= 1'b0;
            r_gap_cnt     <= '0;
            r_state       <= enable ? S_WAIT_GAP : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign table_idx    = r_table_idx;
  assign spawn_valid  = r_spawn_valid;
  assign spawn_slot   = r_spawn_slot;
  assign spawn_x      = r_spawn_x;
  assign spawn_y      = r_spawn_y;
  assign active_mask  = r_active_mask;
  assign active_count = r_active_count;

endmodule
`default_nettype wire

// File: tb/tb_log_spawn_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_log_spawn_scheduler : directed, table-driven bench for log_spawn_scheduler
// Revision: 1.0
// ==========================================================================
module tb_log_spawn_scheduler;
  localparam int NUM_LOGS = 30;
  localparam int IDX_W    = 5;
  localparam int OFFSET_W = 9;

  logic                CLK = 1'b0;
  logic                resetN = 1'b0;
  logic                enable = 1'b0;
  logic                startOfFrame = 1'b0;
  logic [IDX_W-1:0]    table_idx;
  logic [OFFSET_W-1:0] offset_x_in;
  logic [OFFSET_W-1:0] offset_y_in;
  logic                spawn_valid;
  logic                spawn_ready = 1'b0;
  logic [IDX_W-1:0]    spawn_slot;
  logic [OFFSET_W-1:0] spawn_x;
  logic [OFFSET_W-1:0] spawn_y;
  logic                despawn_valid = 1'b0;
  logic [IDX_W-1:0]    despawn_slot = '0;
  logic [NUM_LOGS-1:0] active_mask;
  logic [IDX_W:0]      active_count;

  logic [OFFSET_W-1:0] tbl_x [NUM_LOGS];
  logic [OFFSET_W-1:0] tbl_y [NUM_LOGS];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic                desp_en;
    logic [IDX_W-1:0]    desp_slot;
    logic [IDX_W-1:0]    exp_slot;
    int                  entry;
    logic [NUM_LOGS-1:0] exp_mask;
    logic [IDX_W:0]      exp_count;
    logic [IDX_W-1:0]    exp_tidx;
  } vec_t;

  vec_t vecs [27];

  log_spawn_scheduler #(
    .NUM_LOGS(30), .IDX_W(5), .OFFSET_W(9), .SPAWN_GAP(8), .MAX_ACTIVE(8)
  ) dut (
    .CLK          (CLK),
    .resetN       (resetN),
    .enable       (enable),
    .startOfFrame (startOfFrame),
    .table_idx    (table_idx),
    .offset_x_in  (offset_x_in),
    .offset_y_in  (offset_y_in),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_slot   (spawn_slot),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .despawn_valid(despawn_valid),
    .despawn_slot (despawn_slot),
    .active_mask  (active_mask),
    .active_count (active_count)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    offset_x_in = '0;
    offset_y_in = '0;
    if (int'(table_idx) < NUM_LOGS) begin
      offset_x_in = tbl_x[table_idx];
      offset_y_in = tbl_y[table_idx];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Each pulse is sampled by the last edge of its iteration; returns 1ns after it.
  task automatic pulses(input int n);
    repeat (n) begin
      cyc();
      cyc();
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic expect_offer(input string tag, input logic [IDX_W-1:0] slot, input int entry);
    cyc();
    cyc();
    chk({tag, "_early"}, spawn_valid, 0);
    cyc();
    chk({tag, "_valid"}, spawn_valid, 1);
    chk({tag, "_slot"}, spawn_slot, slot);
    chk({tag, "_x"}, spawn_x, tbl_x[entry]);
    chk({tag, "_y"}, spawn_y, tbl_y[entry]);
  endtask

  task automatic despawn(input logic [IDX_W-1:0] s);
    despawn_valid = 1'b1;
    despawn_slot  = s;
    cyc();
    despawn_valid = 1'b0;
  endtask

  task automatic accept();
    spawn_ready = 1'b1;
    cyc();
    spawn_ready = 1'b0;
  endtask

  task automatic chk_after(input string tag, input logic [NUM_LOGS-1:0] mask,
                           input logic [IDX_W:0] cnt, input logic [IDX_W-1:0] tidx);
    chk({tag, "_valid_drop"}, spawn_valid, 0);
    chk({tag, "_mask"}, active_mask, mask);
    chk({tag, "_count"}, active_count, cnt);
    chk({tag, "_tidx"}, table_idx, tidx);
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    if (v.desp_en) despawn(v.desp_slot);
    pulses(8);
    expect_offer(tag, v.exp_slot, v.entry);
    accept();
    chk_after(tag, v.exp_mask, v.exp_count, v.exp_tidx);
  endtask

  initial begin
    int unstable;
    unstable = 0;
    for (int i = 0; i < NUM_LOGS; i++) begin
      tbl_x[i] = OFFSET_W'(i * 7 + 3);
      tbl_y[i] = OFFSET_W'(i * 11 + 1);
    end
    tbl_x[0] = 9'h0E6;
    tbl_y[0] = 9'h0FF;

    // Spawns 2..8 fill slots 1..7 from entries 1..7.
    for (int i = 0; i < 7; i++) begin
      vecs[i].desp_en   = 1'b0;
      vecs[i].desp_slot = '0;
      vecs[i].exp_slot  = IDX_W'(i + 1);
      vecs[i].entry     = i + 1;
      vecs[i].exp_mask  = NUM_LOGS'((64'd1 << (i + 2)) - 64'd1);
      vecs[i].exp_count = (IDX_W + 1)'(i + 2);
      vecs[i].exp_tidx  = IDX_W'(i + 2);
    end
    // Spawns 12..31: free one slot, the refill takes it; last one wraps to entry 0.
    for (int j = 0; j < 20; j++) begin
      vecs[7 + j].desp_en   = 1'b1;
      vecs[7 + j].desp_slot = IDX_W'(j % 8);
      vecs[7 + j].exp_slot  = IDX_W'(j % 8);
      vecs[7 + j].entry     = (11 + j) % NUM_LOGS;
      vecs[7 + j].exp_mask  = NUM_LOGS'(8'hFF);
      vecs[7 + j].exp_count = (IDX_W + 1)'(8);
      vecs[7 + j].exp_tidx  = IDX_W'((12 + j) % NUM_LOGS);
    end

    // Reset with enable already high: everything holds at zero.
    enable = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", spawn_valid, 0);
    chk("rst_tidx", table_idx, 0);
    chk("rst_slot", spawn_slot, 0);
    chk("rst_x", spawn_x, 0);
    chk("rst_y", spawn_y, 0);
    chk("rst_mask", active_mask, 0);
    chk("rst_count", active_count, 0);
    resetN = 1'b1;

    // First spawn and backpressure.
    pulses(8);
    expect_offer("first", 5'd0, 0);
    repeat (20) begin
      cyc();
      if (spawn_valid !== 1'b1 || spawn_slot !== 5'd0 ||
          spawn_x !== 9'h0E6 || spawn_y !== 9'h0FF) unstable++;
    end
    chk("backpressure_unstable_cycles", unstable, 0);
    accept();
    chk_after("first", 30'h1, 6'd1, 5'd1);

    for (int n = 0; n < 7; n++) apply_vec(vecs[n], n);

    // Cap reached: no ninth offer; out-of-range despawn ignored.
    pulses(8);
    repeat (12) cyc();
    chk("cap_no_offer", spawn_valid, 0);
    despawn(5'd31);
    chk("cap_oob_count", active_count, 8);
    chk("cap_oob_mask", active_mask, 30'hFF);
    cyc();
    chk("cap_still_waiting", spawn_valid, 0);
    despawn(5'd3);
    chk("cap_desp_count", active_count, 7);
    chk("cap_desp_mask", active_mask, 30'hF7);
    expect_offer("cap_refill", 5'd3, 8);
    accept();
    chk_after("cap_refill", 30'hFF, 6'd8, 5'd9);

    // Same-edge accept of slot 5 with despawn of slot 0.
    despawn(5'd5);
    chk("sim_pre_count", active_count, 7);
    pulses(8);
    expect_offer("sim_diff", 5'd5, 9);
    spawn_ready   = 1'b1;
    despawn_valid = 1'b1;
    despawn_slot  = 5'd0;
    cyc();
    spawn_ready   = 1'b0;
    despawn_valid = 1'b0;
    chk_after("sim_diff", 30'hFE, 6'd7, 5'd10);

    // Same-edge despawn of the slot being accepted is ignored.
    pulses(8);
    expect_offer("sim_same", 5'd0, 10);
    spawn_ready   = 1'b1;
    despawn_valid = 1'b1;
    despawn_slot  = 5'd0;
    cyc();
    spawn_ready   = 1'b0;
    despawn_valid = 1'b0;
    chk_after("sim_same", 30'hFF, 6'd8, 5'd11);

    for (int n = 7; n < 27; n++) apply_vec(vecs[n], n);

    // Enable dropped while waiting in FIND_SLOT at the cap.
    pulses(8);
    repeat (4) cyc();
    chk("find_stuck", spawn_valid, 0);
    enable = 1'b0;
    cyc();
    despawn(5'd2);
    chk("find_desp_count", active_count, 7);
    despawn(5'd2);
    chk("redundant_desp_count", active_count, 7);
    repeat (6) cyc();
    chk("find_drop_no_offer", spawn_valid, 0);
    enable = 1'b1;
    cyc();

    // Enable dropped mid-gap: the frame count restarts from zero.
    pulses(4);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    pulses(7);
    repeat (5) cyc();
    chk("gap_cleared_no_offer", spawn_valid, 0);
    pulses(1);
    expect_offer("after_gap", 5'd2, 1);

    // Asynchronous reset while the offer is pending.
    resetN = 1'b0;
    #2;
    chk("async_rst_valid", spawn_valid, 0);
    chk("async_rst_mask", active_mask, 0);
    chk("async_rst_count", active_count, 0);
    chk("async_rst_tidx", table_idx, 0);
    cyc();
    resetN = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
